// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IFU) and load/store (LSU).
// One transaction in flight: latch the grant, issue to memory, wait under a watchdog, return to owner.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [AW-1:0]     ifu_addr,
    output logic              ifu_resp_valid,
    input  logic              ifu_resp_ready,
    output logic [DW-1:0]     ifu_rdata,
    output logic              ifu_resp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [AW-1:0]     lsu_addr,
    input  logic              lsu_wen,
    input  logic [DW-1:0]     lsu_wdata,
    input  logic [DW/8-1:0]   lsu_wmask,
    output logic              lsu_resp_valid,
    input  logic              lsu_resp_ready,
    output logic [DW-1:0]     lsu_rdata,
    output logic              lsu_resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_wen,
    output logic [DW-1:0]     mem_wdata,
    output logic [DW/8-1:0]   mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_resp_err
);

    localparam int MW = DW / 8;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    state_t          r_state;
    state_t          w_state_nxt;
    owner_t          r_owner;
    owner_t          r_last_grant;
    logic [AW-1:0]   r_addr;
    logic            r_wen;
    logic [DW-1:0]   r_wdata;
    logic [MW-1:0]   r_wmask;
    logic [DW-1:0]   r_rdata;
    logic            r_err;
    logic [TW-1:0]   r_timer;

    logic            w_gnt_ifu;
    logic            w_gnt_lsu;
    logic            w_owner_ready;
    logic            w_timeout;
    logic            w_ifu_own;
    logic            w_lsu_own;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        w_gnt_ifu = 1'b0;
        w_gnt_lsu = 1'b0;
        if (ifu_req_valid && lsu_req_valid) begin
            if (r_last_grant == OWN_IFU) begin
                w_gnt_lsu = 1'b1;
            end else begin
                w_gnt_ifu = 1'b1;
            end
        end else if (ifu_req_valid) begin
            w_gnt_ifu = 1'b1;
        end else if (lsu_req_valid) begin
            w_gnt_lsu = 1'b1;
        end else begin
            w_gnt_ifu = 1'b0;
            w_gnt_lsu = 1'b0;
        end
    end

    assign ifu_req_ready = (r_state == S_IDLE) && w_gnt_ifu;
    assign lsu_req_ready = (r_state == S_IDLE) && w_gnt_lsu;

    assign w_owner_ready = (r_owner == OWN_IFU) ? ifu_resp_ready : lsu_resp_ready;
    // The watchdog only exists when TIMEOUT is non-zero; the timer itself never wraps into a false hit.
    assign w_timeout     = (TIMEOUT != 0) && (r_timer == TMO_LAST);

    // Next-state decode for the single-transaction FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_ifu || w_gnt_lsu) begin
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid || w_timeout) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (w_owner_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latches, response capture, ownership and watchdog timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= OWN_IFU;
            r_last_grant <= OWN_IFU;
            r_addr       <= {AW{1'b0}};
            r_wen        <= 1'b0;
            r_wdata      <= {DW{1'b0}};
            r_wmask      <= {MW{1'b0}};
            r_rdata      <= {DW{1'b0}};
            r_err        <= 1'b0;
            r_timer      <= {TW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_lsu) begin
                        r_owner      <= OWN_LSU;
                        r_last_grant <= OWN_LSU;
                        r_addr       <= lsu_addr;
                        r_wen        <= lsu_wen;
                        r_wdata      <= lsu_wdata;
                        r_wmask      <= lsu_wmask;
                    end else if (w_gnt_ifu) begin
                        r_owner      <= OWN_IFU;
                        r_last_grant <= OWN_IFU;
                        r_addr       <= ifu_addr;
                        r_wen        <= 1'b0;
                        r_wdata      <= {DW{1'b0}};
                        r_wmask      <= {MW{1'b0}};
                    end else begin
                        r_owner      <= r_owner;
                    end
                end
                S_REQ: begin
                    if (mem_req_ready) begin
                        r_timer <= {TW{1'b0}};
                    end else begin
                        r_timer <= r_timer;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_rdata <= mem_rdata;
                        r_err   <= mem_resp_err;
                    end else if (w_timeout) begin
                        r_rdata <= {DW{1'b0}};
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_RESP: begin
                    r_rdata <= r_rdata;
                end
                default: begin
                    r_timer <= {TW{1'b0}};
                end
            endcase
        end
    end

    assign w_ifu_own      = (r_state == S_RESP) && (r_owner == OWN_IFU);
    assign w_lsu_own      = (r_state == S_RESP) && (r_owner == OWN_LSU);

    assign ifu_resp_valid = w_ifu_own;
    assign ifu_rdata      = w_ifu_own ? r_rdata : {DW{1'b0}};
    assign ifu_resp_err   = w_ifu_own && r_err;
    assign lsu_resp_valid = w_lsu_own;
    assign lsu_rdata      = w_lsu_own ? r_rdata : {DW{1'b0}};
    assign lsu_resp_err   = w_lsu_own && r_err;

    assign mem_req_valid  = (r_state == S_REQ);
    assign mem_addr       = r_addr;
    assign mem_wen        = r_wen;
    assign mem_wdata      = r_wdata;
    assign mem_wmask      = r_wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory requests and responses,
// a negedge monitor pops and compares them whenever the DUT completes a handshake.
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = 4;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_resp_err;
    logic [AW-1:0]   ifu_addr;
    logic [DW-1:0]   ifu_rdata;
    logic            lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
    logic [AW-1:0]   lsu_addr;
    logic [DW-1:0]   lsu_wdata, lsu_rdata;
    logic [MW-1:0]   lsu_wmask;
    logic            mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic [MW-1:0]   mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
        .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wen;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
    } mreq_t;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    mreq_t exp_mem_q[$];
    rsp_t  exp_ifu_q[$];
    rsp_t  exp_lsu_q[$];
    rsp_t  mem_rsp_q[$];

    int checks = 0;
    int errors = 0;

    // memory model controls (written only by the stimulus process)
    int mem_stall  = 0;
    int mem_lat    = 0;
    bit mem_drop   = 1'b0;
    int inject_req = 0;

    function automatic void chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: stalls mem_req_ready, answers after a latency, can drop or inject spurious responses.
    int stall_left  = -1;
    bit accepted    = 1'b0;
    int lat_left    = 0;
    int inject_done = 0;
    initial begin
        rsp_t r;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        mem_resp_err   = 1'b0;
        forever begin
            cyc();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_rdata      = 32'h0;
            mem_resp_err   = 1'b0;
            if (rst) begin
                accepted   = 1'b0;
                stall_left = -1;
            end else if (inject_req != inject_done) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = 32'hDEAD_BEEF;
                mem_resp_err   = 1'b1;
                inject_done++;
            end else if (accepted) begin
                if (mem_drop) begin
                    accepted = 1'b0;
                end else if (lat_left == 0) begin
                    if (mem_rsp_q.size() != 0) begin
                        r = mem_rsp_q.pop_front();
                        mem_rdata    = r.rdata;
                        mem_resp_err = r.err;
                    end
                    mem_resp_valid = 1'b1;
                    accepted       = 1'b0;
                end else begin
                    lat_left--;
                end
            end else if (mem_req_valid) begin
                if (stall_left < 0) stall_left = mem_stall;
                if (stall_left == 0) begin
                    mem_req_ready = 1'b1;
                    accepted      = 1'b1;
                    lat_left      = mem_lat;
                    stall_left    = -1;
                end else begin
                    stall_left--;
                end
            end
        end
    end

    // Monitor: scoreboard pops on handshakes plus hold/idle-value rules.
    initial begin
        mreq_t m;
        rsp_t  r;
        logic        p_mv, p_mr, p_iv, p_ir, p_lv, p_lr;
        logic [68:0] p_mf;
        logic [32:0] p_ip, p_lp;
        p_mv = 1'b0; p_mr = 1'b0; p_iv = 1'b0; p_ir = 1'b0; p_lv = 1'b0; p_lr = 1'b0;
        p_mf = 69'h0; p_ip = 33'h0; p_lp = 33'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_mv = 1'b0; p_iv = 1'b0; p_lv = 1'b0;
            end else begin
                chk("one_req_ready", {ifu_req_ready, lsu_req_ready} == 2'b11, 1'b0);
                chk("one_resp_valid", {ifu_resp_valid, lsu_resp_valid} == 2'b11, 1'b0);
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_mem_q.size() == 0) begin
                        chk("mem_req_unexpected", 1'b1, 1'b0);
                    end else begin
                        m = exp_mem_q.pop_front();
                        chk("mem_req_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, m);
                    end
                end
                if (ifu_resp_valid && ifu_resp_ready) begin
                    if (exp_ifu_q.size() == 0) begin
                        chk("ifu_resp_unexpected", 1'b1, 1'b0);
                    end else begin
                        r = exp_ifu_q.pop_front();
                        chk("ifu_resp", {ifu_rdata, ifu_resp_err}, r);
                    end
                end
                if (lsu_resp_valid && lsu_resp_ready) begin
                    if (exp_lsu_q.size() == 0) begin
                        chk("lsu_resp_unexpected", 1'b1, 1'b0);
                    end else begin
                        r = exp_lsu_q.pop_front();
                        chk("lsu_resp", {lsu_rdata, lsu_resp_err}, r);
                    end
                end
                if (!ifu_resp_valid) chk("ifu_idle_resp_zero", {ifu_rdata, ifu_resp_err}, 33'h0);
                if (!lsu_resp_valid) chk("lsu_idle_resp_zero", {lsu_rdata, lsu_resp_err}, 33'h0);
                if (p_mv && !p_mr) begin
                    chk("mem_req_held", mem_req_valid, 1'b1);
                    chk("mem_fields_held", {mem_addr, mem_wen, mem_wdata, mem_wmask}, p_mf);
                end
                if (p_iv && !p_ir) chk("ifu_resp_held", {ifu_resp_valid, ifu_rdata, ifu_resp_err}, {1'b1, p_ip});
                if (p_lv && !p_lr) chk("lsu_resp_held", {lsu_resp_valid, lsu_rdata, lsu_resp_err}, {1'b1, p_lp});
                p_mv = mem_req_valid;  p_mr = mem_req_ready;
                p_mf = {mem_addr, mem_wen, mem_wdata, mem_wmask};
                p_iv = ifu_resp_valid; p_ir = ifu_resp_ready; p_ip = {ifu_rdata, ifu_resp_err};
                p_lv = lsu_resp_valid; p_lr = lsu_resp_ready; p_lp = {lsu_rdata, lsu_resp_err};
            end
        end
    end

    task automatic chk_zero();
        chk("zero_ctrl", {ifu_req_ready, ifu_resp_valid, ifu_resp_err, lsu_req_ready,
                          lsu_resp_valid, lsu_resp_err, mem_req_valid, mem_wen}, 8'h00);
        chk("zero_rdata", {ifu_rdata, lsu_rdata}, 64'h0);
        chk("zero_mem", {mem_addr, mem_wdata, mem_wmask}, 68'h0);
    endtask

    task automatic issue(input bit is_lsu, input logic [31:0] a, input logic w, input logic [31:0] wd,
                         input logic [3:0] wm, input logic [31:0] rd, input logic er,
                         input bit mem_answers, input bit expect_resp);
        mreq_t m;
        rsp_t  r;
        bit    hs;
        m.addr  = a;
        m.wen   = is_lsu ? w  : 1'b0;
        m.wdata = is_lsu ? wd : 32'h0;
        m.wmask = is_lsu ? wm : 4'h0;
        exp_mem_q.push_back(m);
        r.rdata = rd;
        r.err   = er;
        if (mem_answers) mem_rsp_q.push_back(r);
        if (expect_resp) begin
            if (is_lsu) exp_lsu_q.push_back(r);
            else        exp_ifu_q.push_back(r);
        end
        if (is_lsu) begin
            lsu_req_valid = 1'b1; lsu_addr = a; lsu_wen = w; lsu_wdata = wd; lsu_wmask = wm;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = a;
        end
        hs = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (is_lsu ? lsu_req_ready : ifu_req_ready) begin
                hs = 1'b1;
                break;
            end
        end
        chk("req_handshake", hs, 1'b1);
        cyc();
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (exp_ifu_q.size() == 0 && exp_lsu_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("resp_drained", ok, 1'b1);
        cyc();
    endtask

    // Minimum-latency IFU fetch, checked cycle by cycle from an idle arbiter.
    task automatic s1_fetch();
        mreq_t m;
        rsp_t  r;
        mem_stall = 0; mem_lat = 0; mem_drop = 1'b0;
        m.addr = 32'h8000_0000; m.wen = 1'b0; m.wdata = 32'h0; m.wmask = 4'h0;
        exp_mem_q.push_back(m);
        r.rdata = 32'h0000_0413; r.err = 1'b0;
        mem_rsp_q.push_back(r);
        exp_ifu_q.push_back(r);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        @(negedge clk);
        chk("s1_c0_ifu_ready", {ifu_req_ready, lsu_req_ready, mem_req_valid}, 3'b100);
        cyc();
        ifu_req_valid = 1'b0; ifu_addr = 32'h0;
        @(negedge clk);
        chk("s1_c1_mem_req", {mem_req_valid, mem_addr}, {1'b1, 32'h8000_0000});
        cyc();
        @(negedge clk);
        chk("s1_c2_no_resp", ifu_resp_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk("s1_c3_resp", {ifu_resp_valid, ifu_rdata, ifu_resp_err}, {1'b1, 32'h0000_0413, 1'b0});
        chk("s1_c3_lsu_quiet", {lsu_resp_valid, lsu_req_ready}, 2'b00);
        cyc();
    endtask

    initial begin
        mreq_t m;
        rsp_t  r;
        int    n_l, n_i, k;
        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = 32'h0; ifu_resp_ready = 1'b1;
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        lsu_resp_ready = 1'b1;
        repeat (3) cyc();
        @(negedge clk);
        chk_zero();
        cyc();
        rst = 1'b0;

        // Both requesters held valid from the first cycle: LSU, IFU, LSU, IFU.
        m.wen = 1'b0; m.wdata = 32'h0; m.wmask = 4'h0;
        m.addr = 32'h2000_0000; exp_mem_q.push_back(m);
        m.addr = 32'h8000_0100; exp_mem_q.push_back(m);
        m.addr = 32'h2000_0000; exp_mem_q.push_back(m);
        m.addr = 32'h8000_0100; exp_mem_q.push_back(m);
        r.rdata = 32'hAAAA_0001; r.err = 1'b0; mem_rsp_q.push_back(r); exp_lsu_q.push_back(r);
        r.rdata = 32'hBBBB_0002; r.err = 1'b0; mem_rsp_q.push_back(r); exp_ifu_q.push_back(r);
        r.rdata = 32'hAAAA_0003; r.err = 1'b1; mem_rsp_q.push_back(r); exp_lsu_q.push_back(r);
        r.rdata = 32'hBBBB_0004; r.err = 1'b0; mem_rsp_q.push_back(r); exp_ifu_q.push_back(r);
        lsu_req_valid = 1'b1; lsu_addr = 32'h2000_0000;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        n_l = 0; n_i = 0;
        for (int i = 0; i < 400 && (lsu_req_valid || ifu_req_valid); i++) begin
            @(negedge clk);
            if (i == 0) chk("s2_first_grant_lsu", {lsu_req_ready, ifu_req_ready}, 2'b10);
            if (lsu_req_ready) n_l++;
            if (ifu_req_ready) n_i++;
            cyc();
            if (n_l == 2) begin lsu_req_valid = 1'b0; lsu_addr = 32'h0; end
            if (n_i == 2) begin ifu_req_valid = 1'b0; ifu_addr = 32'h0; end
        end
        chk("s2_grant_counts", {n_l[7:0], n_i[7:0]}, 16'h0202);
        wait_done();

        s1_fetch();

        // LSU write with memory stalling; wdata is cleared right after the handshake.
        mem_stall = 5; mem_lat = 1;
        issue(1'b1, 32'h8000_1000, 1'b1, 32'h1234_5678, 4'hF, 32'h5A5A_0000, 1'b0, 1'b1, 1'b1);
        wait_done();

        // REQ stall longer than the watchdog, with response backpressure.
        mem_stall = 20; mem_lat = 3;
        ifu_resp_ready = 1'b0;
        issue(1'b0, 32'h8000_0200, 1'b0, 32'h0, 4'h0, 32'h1234_ABCD, 1'b0, 1'b1, 1'b1);
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ifu_resp_valid) begin k = i; break; end
        end
        chk("s4_resp_latency", k, 32'd26);
        repeat (3) cyc();
        ifu_resp_ready = 1'b1;
        wait_done();

        // No memory response: watchdog returns err=1, rdata=0 sixteen cycles after WAIT entry.
        mem_stall = 0; mem_lat = 0; mem_drop = 1'b1;
        issue(1'b1, 32'h8000_2000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (lsu_resp_valid) begin k = i; break; end
        end
        chk("s5_timeout_latency", k, 32'd18);
        wait_done();
        mem_drop = 1'b0;
        inject_req++;
        repeat (4) cyc();
        @(negedge clk);
        chk("s5_spurious_ignored", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 3'b000);
        cyc();
        issue(1'b1, 32'h8000_2004, 1'b0, 32'h0, 4'h0, 32'h7777_0000, 1'b0, 1'b1, 1'b1);
        wait_done();

        // Reset while waiting on memory abandons the transaction silently.
        mem_lat = 10;
        issue(1'b0, 32'h8000_0300, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        chk_zero();
        cyc();
        rst = 1'b0;
        repeat (15) cyc();
        @(negedge clk);
        chk("s6_no_resp_after_rst", {ifu_resp_valid, lsu_resp_valid, mem_req_valid}, 3'b000);
        cyc();
        s1_fetch();

        repeat (5) cyc();
        chk("queues_empty", exp_mem_q.size() + exp_ifu_q.size() + exp_lsu_q.size() + mem_rsp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete, expected $finish before 100000");
        $fatal(1, "global timeout");
    end

endmodule
